beat_judge: RTL and testbench
=============================

Name: beat_judge

Overview:
- Judges the player's key presses against the circles that the game state machine spawns.
- Consumes the `spawn`/`circletype` outputs and the shared USB `keycode`, and produces the `playerpass` input read by the game state machine in its finished state.
- Holds one hit-window timer per circle type, counts hits and misses, and emits one-cycle feedback pulses for the sprite and score-display logic.

Parameters:
- HIT_WINDOW, 60: cycles a spawned circle stays hittable (≥2).
- PASS_THRESHOLD, 3: hits required for playerpass (0..15).
- KEY0, 8'd4: keycode that hits circletype 0 (A).
- KEY1, 8'd22: keycode that hits circletype 1 (S).
- KEY2, 8'd7: keycode that hits circletype 2 (D).
- KEY3, 8'd9: keycode that hits circletype 3 (F).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous game clear; tie to main-screen indicator.
- spawn  in  1  one-cycle circle spawn strobe.
- circletype  in  2  type of spawned circle; valid only with spawn.
- keycode  in  8  current USB keycode, level, 0 = none.
- active  out  4  bit t = circle of type t is live.
- hit_count  out  4  saturating hit counter.
- miss_count  out  4  saturating miss counter.
- hit_pulse  out  1  one-cycle pulse on a hit.
- miss_pulse  out  1  one-cycle pulse on one or more misses.
- playerpass  out  1  hit_count >= PASS_THRESHOLD, combinational from the hit_count register.

Behaviour:
- Reset and clear: timers, active, counters, pulses and prev_key all go to 0. Reset has priority over clear. Either one, asserted mid-game, discards all live circles with no misses counted.
- Press detection:
  - prev_key registers keycode every cycle.
  - press[t] = (keycode==KEYt) && (prev_key!=KEYt).
  - A held key produces one press only.
  - At most one press per cycle, since keycode carries a single key.
- Per slot t, one state bit plus a timer of $clog2(HIT_WINDOW+1) bits:
  - IDLE → LIVE on spawn with circletype==t; timer loads HIT_WINDOW.
  - In LIVE, the timer decrements each cycle.
  - LIVE with press[t] → IDLE, counts a hit.
  - LIVE with timer==1 and no press → IDLE, counts a miss; the slot is live for exactly HIT_WINDOW cycles.
  - press[t] while IDLE is ignored: no hit, no miss.
- Simultaneous events, resolved on the state before update:
  - press[t] and timer expiry in the same cycle → hit.
  - spawn[t] while slot t is LIVE with no press → miss for the old circle; the timer reloads and the slot stays LIVE.
  - spawn[t] with press[t] while LIVE → hit for the old circle; the new circle loads.
  - spawn[t] with press[t] while IDLE → press ignored; the circle loads.
  - Several slots expiring in one cycle → miss_count += popcount of the misses, saturating at 15. A single miss_pulse is emitted.
- Counter, active and pulse timing:
  - Counters update on the clock edge after the event; active updates on the same edge.
  - hit_pulse and miss_pulse are registered and high for the one cycle following the event edge.
  - Both counters saturate at 15, with no wrap.
- playerpass: no added latency over hit_count. It stays valid until clear.

Decomposition:
- beat_pkg holds:
  - typedef circletype_t (logic[1:0]);
  - CNT_W=4;
  - default KEY constants;
  - function sat_add(cnt, inc).
- Sub-module beat_slot, instantiated 4× with generate. It contains the IDLE/LIVE FSM and the down-counter, and outputs live, hit and miss for its lane.
- The top level holds press detection, counters and pulses.

Test Plan (HIT_WINDOW=8, PASS_THRESHOLD=3):
- Spawn type 0, then keycode=4 three cycles later → active[0] clears next edge; hit_count=1, hit_pulse high for 1 cycle.
- Spawn type 2, then no key → active[2] is high for 8 cycles, then miss_count=1 and miss_pulse=1; hit_count stays 0.
- Hold keycode=22 for 20 cycles across two type-1 spawns (second spawned after the first is judged) → 1 hit, 1 miss. A held key never re-hits.
- Spawn types 0..3 on consecutive cycles, no keys → the slots expire on consecutive cycles, miss_count=4 and miss_pulse high 4 cycles. Repeat until saturated → miss_count holds 15.
- Three hits on types 0, 1, 3 → playerpass=1 the cycle hit_count reaches 3. Then pulse clear → all counters 0, playerpass=0.
- Spawn type 3 and, on its expiry cycle, press keycode=9 → hit, not miss. Respawn type 3 while it is live → miss_count+1, timer reloads to 8.

Source files
------------

// File: rtl/beat_pkg.sv
// Shared types, widths and helpers for the beat judge and its per-lane slots.
package beat_pkg;

    typedef logic [1:0] circletype_t;

    typedef enum logic {
        StIdle,
        StLive
    } slot_state_t;

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned NUM_SLOTS = 4;

    localparam logic [7:0] KEY0_DEFAULT = 8'd4;
    localparam logic [7:0] KEY1_DEFAULT = 8'd22;
    localparam logic [7:0] KEY2_DEFAULT = 8'd7;
    localparam logic [7:0] KEY3_DEFAULT = 8'd9;

    // Saturating add; inc is at most NUM_SLOTS, so the sum fits in CNT_W+1 bits.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [2:0]       inc);
        logic [CNT_W:0] w_sum;
        w_sum = {1'b0, cnt} + {{(CNT_W - 2){1'b0}}, inc};
        if (w_sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end
        return w_sum[CNT_W-1:0];
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] vec);
        return {2'b00, vec[0]} + {2'b00, vec[1]} + {2'b00, vec[2]} + {2'b00, vec[3]};
    endfunction

endpackage

// File: rtl/beat_slot.sv
// One hit-window lane: IDLE/LIVE state plus a down-counter, reporting a hit or miss
// for the circle it held on the cycle the circle is judged.
module beat_slot
    import beat_pkg::*;
#(
    parameter int unsigned HIT_WINDOW = 60
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic i_spawn,
    input  logic i_press,
    output logic o_live,
    output logic o_hit,
    output logic o_miss
);

    localparam int unsigned TIMER_W = $clog2(HIT_WINDOW + 1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(HIT_WINDOW);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(1);

    slot_state_t        r_state;
    slot_state_t        w_state_next;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_next;
    logic               w_expiring;

    assign w_expiring = (r_timer == TIMER_LAST);
    assign o_live     = (r_state == StLive);

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            r_state <= StIdle;
            r_timer <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
        end
    end

    // Judgement uses the pre-update state; a spawn always (re)loads the window afterwards.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        o_hit        = 1'b0;
        o_miss       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_spawn) begin
                    w_state_next = StLive;
                    w_timer_next = TIMER_LOAD;
                end
            end
            StLive: begin
                w_timer_next = r_timer - TIMER_LAST;
                if (i_press) begin
                    o_hit        = 1'b1;
                    w_state_next = StIdle;
                end else if (i_spawn || w_expiring) begin
                    o_miss       = 1'b1;
                    w_state_next = StIdle;
                end
                if (i_spawn) begin
                    w_state_next = StLive;
                    w_timer_next = TIMER_LOAD;
                end
            end
        endcase
    end

endmodule

// File: rtl/beat_judge.sv
// Judges key presses against spawned circles: press edge detection, four hit-window
// lanes, saturating hit/miss counters, feedback pulses and the pass flag.
module beat_judge
    import beat_pkg::*;
#(
    parameter int unsigned HIT_WINDOW     = 60,
    parameter int unsigned PASS_THRESHOLD = 3,
    parameter logic [7:0]  KEY0           = KEY0_DEFAULT,
    parameter logic [7:0]  KEY1           = KEY1_DEFAULT,
    parameter logic [7:0]  KEY2           = KEY2_DEFAULT,
    parameter logic [7:0]  KEY3           = KEY3_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic             spawn,
    input  circletype_t      circletype,
    input  logic [7:0]       keycode,
    output logic [3:0]       active,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic             hit_pulse,
    output logic             miss_pulse,
    output logic             playerpass
);

    localparam logic [NUM_SLOTS-1:0][7:0] KEYS = {KEY3, KEY2, KEY1, KEY0};

    logic [7:0]           r_prev_key;
    logic [CNT_W-1:0]     r_hit_count;
    logic [CNT_W-1:0]     r_miss_count;
    logic                 r_hit_pulse;
    logic                 r_miss_pulse;

    logic [NUM_SLOTS-1:0] w_press;
    logic [NUM_SLOTS-1:0] w_spawn;
    logic [NUM_SLOTS-1:0] w_live;
    logic [NUM_SLOTS-1:0] w_hit;
    logic [NUM_SLOTS-1:0] w_miss;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        // A held key only counts on the cycle it first appears.
        assign w_press[g] = (keycode == KEYS[g]) && (r_prev_key != KEYS[g]);
        assign w_spawn[g] = spawn && (circletype == circletype_t'(g));

        beat_slot #(
            .HIT_WINDOW (HIT_WINDOW)
        ) u_slot (
            .Clk     (Clk),
            .Reset   (Reset),
            .clear   (clear),
            .i_spawn (w_spawn[g]),
            .i_press (w_press[g]),
            .o_live  (w_live[g]),
            .o_hit   (w_hit[g]),
            .o_miss  (w_miss[g])
        );
    end

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            r_prev_key   <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_hit_pulse  <= 1'b0;
            r_miss_pulse <= 1'b0;
        end else begin
            r_prev_key   <= keycode;
            r_hit_count  <= sat_add(r_hit_count, popcount4(w_hit));
            r_miss_count <= sat_add(r_miss_count, popcount4(w_miss));
            r_hit_pulse  <= |w_hit;
            r_miss_pulse <= |w_miss;
        end
    end

    assign active     = w_live;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
    assign hit_pulse  = r_hit_pulse;
    assign miss_pulse = r_miss_pulse;
    assign playerpass = (32'(r_hit_count) >= PASS_THRESHOLD);

endmodule

// File: tb/tb_beat_judge.sv
// Scoreboarded random and directed bench for beat_judge with an event-level reference model.
module tb_beat_judge;

    localparam int unsigned HW = 8;
    localparam int unsigned PT = 3;

    logic       Clk;
    logic       Reset;
    logic       clear;
    logic       spawn;
    logic [1:0] circletype;
    logic [7:0] keycode;
    logic [3:0] active;
    logic [3:0] hit_count;
    logic [3:0] miss_count;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       playerpass;

    beat_judge #(
        .HIT_WINDOW     (HW),
        .PASS_THRESHOLD (PT),
        .KEY0           (8'd4),
        .KEY1           (8'd22),
        .KEY2           (8'd7),
        .KEY3           (8'd9)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .clear      (clear),
        .spawn      (spawn),
        .circletype (circletype),
        .keycode    (keycode),
        .active     (active),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .playerpass (playerpass)
    );

    typedef struct packed {
        logic [3:0] active;
        logic [3:0] hits;
        logic [3:0] misses;
        logic       hp;
        logic       mp;
        logic       pass;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: per type, whether a circle is up and the edge at which it times out.
    int   keyv[4] = '{4, 22, 7, 9};
    bit   m_live[4];
    int   m_deadline[4];
    int   m_hits;
    int   m_misses;
    int   m_prev;
    int   m_edge;
    int   cur_key;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit clr, input bit sp, input int ty, input int key);
        exp_t e;
        int   nh;
        int   nm;
        bit   press;
        bit   sp_t;
        @(negedge Clk);
        Reset      = rst;
        clear      = clr;
        spawn      = sp;
        circletype = 2'(ty);
        keycode    = 8'(key);
        m_edge++;
        nh = 0;
        nm = 0;
        if (rst || clr) begin
            for (int t = 0; t < 4; t++) m_live[t] = 1'b0;
            m_hits   = 0;
            m_misses = 0;
            m_prev   = 0;
        end else begin
            for (int t = 0; t < 4; t++) begin
                press = (key == keyv[t]) && (m_prev != keyv[t]);
                sp_t  = sp && (ty == t);
                if (m_live[t]) begin
                    if (press) begin
                        nh++;
                        m_live[t] = 1'b0;
                    end else if (sp_t || m_edge == m_deadline[t]) begin
                        nm++;
                        m_live[t] = 1'b0;
                    end
                end
                if (sp_t) begin
                    m_live[t]     = 1'b1;
                    m_deadline[t] = m_edge + int'(HW);
                end
            end
            m_hits   = (m_hits + nh > 15) ? 15 : m_hits + nh;
            m_misses = (m_misses + nm > 15) ? 15 : m_misses + nm;
            m_prev   = key;
        end
        for (int t = 0; t < 4; t++) e.active[t] = m_live[t];
        e.hits   = 4'(m_hits);
        e.misses = 4'(m_misses);
        e.hp     = (nh > 0);
        e.mp     = (nm > 0);
        e.pass   = (m_hits >= int'(PT));
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, cur_key);
    endtask

    task automatic spawn_t(input int ty);
        drive(0, 0, 1, ty, cur_key);
    endtask

    task automatic key_to(input int key);
        cur_key = key;
        drive(0, 0, 0, 0, cur_key);
    endtask

    // Monitor: every cycle the DUT presents a fresh output set, compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("active", int'(active), int'(e.active));
                chk("hit_count", int'(hit_count), int'(e.hits));
                chk("miss_count", int'(miss_count), int'(e.misses));
                chk("hit_pulse", int'(hit_pulse), int'(e.hp));
                chk("miss_pulse", int'(miss_pulse), int'(e.mp));
                chk("playerpass", int'(playerpass), int'(e.pass));
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        Reset      = 1'b1;
        clear      = 1'b0;
        spawn      = 1'b0;
        circletype = 2'd0;
        keycode    = 8'd0;
        cur_key    = 0;
        m_edge     = 0;
        m_prev     = 0;
        m_hits     = 0;
        m_misses   = 0;
        for (int t = 0; t < 4; t++) begin
            m_live[t]     = 1'b0;
            m_deadline[t] = 0;
        end

        repeat (3) drive(1, 0, 0, 0, 0);
        idle(2);

        // Single hit, three cycles after spawn.
        spawn_t(0);
        idle(2);
        key_to(4);
        key_to(0);
        idle(3);

        // Untouched circle times out.
        spawn_t(2);
        idle(12);

        // Held key across two type-1 circles: one hit, then a miss.
        spawn_t(1);
        idle(2);
        cur_key = 22;
        idle(4);
        spawn_t(1);
        idle(15);
        key_to(0);
        idle(4);

        // Four lanes expiring on consecutive cycles, repeated until the miss counter saturates.
        for (int r = 0; r < 4; r++) begin
            for (int t = 0; t < 4; t++) spawn_t(t);
            idle(10);
        end

        // Three hits reach the pass threshold, then a clear wipes everything.
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            k = (i == 2) ? 3 : i;
            spawn_t(k);
            idle(1);
            key_to(keyv[k]);
            key_to(0);
        end
        idle(2);
        drive(0, 1, 0, 0, 0);
        idle(2);

        // Press on the expiry cycle wins; respawn of a live circle misses the old one.
        spawn_t(3);
        idle(7);
        key_to(9);
        key_to(0);
        spawn_t(3);
        idle(3);
        spawn_t(3);
        idle(10);

        // Clear mid-game with circles live.
        spawn_t(0);
        spawn_t(1);
        idle(2);
        drive(0, 1, 0, 0, 0);
        idle(10);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3, 0) == 0) begin
                case ($urandom_range(5, 0))
                    0: cur_key = 0;
                    1: cur_key = 4;
                    2: cur_key = 22;
                    3: cur_key = 7;
                    4: cur_key = 9;
                    default: cur_key = 5;
                endcase
            end
            if ($urandom_range(199, 0) == 0) begin
                drive(0, 1, 0, 0, cur_key);
            end else if ($urandom_range(499, 0) == 0) begin
                drive(1, 0, 0, 0, cur_key);
            end else begin
                drive(0, 0, ($urandom_range(4, 0) == 0), int'($urandom_range(3, 0)), cur_key);
            end
        end
        cur_key = 0;
        idle(12);

        @(posedge Clk);
        #2;
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
